// File: rtl/vce_pkg.sv
// Shared definitions for the video colour encoder: CPU register map and dot-clock modes.
package vce_pkg;

  localparam logic [2:0] VCE_CR      = 3'd0;
  localparam logic [2:0] VCE_ADDR_LO = 3'd2;
  localparam logic [2:0] VCE_ADDR_HI = 3'd3;
  localparam logic [2:0] VCE_DATA_LO = 3'd4;
  localparam logic [2:0] VCE_DATA_HI = 3'd5;

  typedef enum logic [1:0] {
    DOT_DIV8     = 2'd0,
    DOT_DIV6     = 2'd1,
    DOT_DIV4     = 2'd2,
    DOT_DIV4_ALT = 2'd3
  } dot_mode_t;

  // Master-clock cycles per dot for each mode.
  function automatic logic [3:0] dot_div(input dot_mode_t mode);
    case (mode)
      DOT_DIV8: dot_div = 4'd8;
      DOT_DIV6: dot_div = 4'd6;
      default:  dot_div = 4'd4;
    endcase
  endfunction

endpackage

// File: rtl/vce_dot_clk_gen.sv
// Dot-clock enable generator: a reloading counter emitting a one-cycle pulse every N cycles.
module vce_dot_clk_gen
  import vce_pkg::*;
(
  input  logic       clock,
  input  logic       reset_N,
  input  logic [1:0] mode_i,
  input  logic       restart_i,
  output logic       ck_o
);

  logic [3:0] count_q;
  logic       ck_q;
  logic [3:0] lastCount;

  assign lastCount = dot_div(dot_mode_t'(mode_i)) - 4'd1;

  // A restart lands on the same edge as the new mode, so the first pulse is N cycles later.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      count_q <= 4'd0;
      ck_q    <= 1'b0;
    end else if (restart_i) begin
      count_q <= 4'd0;
      ck_q    <= 1'b0;
    end else if (count_q >= lastCount) begin
      count_q <= 4'd0;
      ck_q    <= 1'b1;
    end else begin
      count_q <= count_q + 4'd1;
      ck_q    <= 1'b0;
    end
  end

  assign ck_o = ck_q;

endmodule

// File: rtl/vce_color_encoder.sv
// Video colour encoder: CPU-programmable colour RAM mapping VDC pixel codes to RGB,
// with background substitution, sync blanking, greyscale and dot-clock generation.
module vce_color_encoder
  import vce_pkg::*;
#(
  parameter int CDEPTH  = 3,
  parameter int CRAM_AW = 9
) (
  input  logic               clock,
  input  logic               reset_N,
  input  logic [CRAM_AW-1:0] VD,
  input  logic               HSYN,
  input  logic               VSYN,
  input  logic [2:0]         A,
  input  logic [7:0]         D_in,
  output logic [7:0]         D_out,
  output logic               D_oe,
  input  logic               RD_n,
  input  logic               WR_n,
  input  logic               CS_n,
  output logic [CDEPTH-1:0]  VIDEO_R,
  output logic [CDEPTH-1:0]  VIDEO_G,
  output logic [CDEPTH-1:0]  VIDEO_B,
  output logic               CK
);

  localparam int CW    = 3 * CDEPTH;
  localparam int DEPTH = 1 << CRAM_AW;

  logic [CW-1:0]      cram [DEPTH];
  logic [CW-1:0]      cramCpu;

  logic               wrActive, rdActive, wrFire, rdFire;
  logic               wrSeen_q, rdSeen_q;
  logic [7:0]         cr_q, cr_d;
  logic [CRAM_AW-1:0] addr_q, addr_d;
  logic [7:0]         latch_q, latch_d;
  logic               commitPending_q, commitPending_d;
  logic [CW-1:0]      commitData_q, commitData_d;
  logic [7:0]         dOut_q, dOut_d;

  logic [CRAM_AW-1:0] pixIdx;
  logic [CW-1:0]      pix_q;
  logic               blank1_q;
  logic [CDEPTH-1:0]  pixG, pixR, pixB, pixGrey;
  logic [CDEPTH+1:0]  pixSum;
  logic [CDEPTH-1:0]  videoR_q, videoG_q, videoB_q;

  // Strobes fire on the first cycle an access is seen, so a long low pulse acts once.
  assign wrActive = ~CS_n & ~WR_n;
  assign rdActive = ~CS_n & ~RD_n;
  assign wrFire   = wrActive & ~wrSeen_q;
  assign rdFire   = rdActive & ~rdSeen_q & ~wrActive;
  assign cramCpu  = cram[addr_q];

  always_comb begin
    cr_d            = cr_q;
    addr_d          = addr_q;
    latch_d         = latch_q;
    commitPending_d = 1'b0;
    commitData_d    = commitData_q;
    dOut_d          = dOut_q;
    if (commitPending_q) begin
      addr_d = addr_q + CRAM_AW'(1);
    end
    if (wrFire) begin
      case (A)
        VCE_CR:      cr_d = D_in;
        VCE_ADDR_LO: addr_d[7:0] = D_in;
        VCE_ADDR_HI: addr_d[CRAM_AW-1:8] = D_in[CRAM_AW-9:0];
        VCE_DATA_LO: latch_d = D_in;
        VCE_DATA_HI: begin
          commitPending_d = 1'b1;
          commitData_d    = {D_in[CW-9:0], latch_q};
        end
        default: ;
      endcase
    end else if (rdFire) begin
      case (A)
        VCE_CR:      dOut_d = cr_q;
        VCE_ADDR_LO: dOut_d = addr_q[7:0];
        VCE_ADDR_HI: dOut_d = 8'(addr_q[CRAM_AW-1:8]);
        VCE_DATA_LO: dOut_d = cramCpu[7:0];
        VCE_DATA_HI: begin
          dOut_d = 8'(cramCpu[CW-1:8]);
          addr_d = addr_q + CRAM_AW'(1);
        end
        default:     dOut_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      wrSeen_q        <= 1'b0;
      rdSeen_q        <= 1'b0;
      cr_q            <= 8'h00;
      addr_q          <= '0;
      latch_q         <= 8'h00;
      commitPending_q <= 1'b0;
      commitData_q    <= '0;
      dOut_q          <= 8'h00;
    end else begin
      wrSeen_q        <= wrActive;
      rdSeen_q        <= rdActive;
      cr_q            <= cr_d;
      addr_q          <= addr_d;
      latch_q         <= latch_d;
      commitPending_q <= commitPending_d;
      commitData_q    <= commitData_d;
      dOut_q          <= dOut_d;
    end
  end

  // Commit lands one cycle after the strobe; the pixel port sees the old entry that cycle.
  always_ff @(posedge clock) begin
    if (commitPending_q) begin
      cram[addr_q] <= commitData_q;
    end
  end

  assign pixIdx = (VD[3:0] == 4'd0) ? {VD[CRAM_AW-1], {(CRAM_AW-1){1'b0}}} : VD;

  assign pixG    = pix_q[CW-1:2*CDEPTH];
  assign pixR    = pix_q[2*CDEPTH-1:CDEPTH];
  assign pixB    = pix_q[CDEPTH-1:0];
  assign pixSum  = {2'b00, pixR} + {2'b00, pixG} + {2'b00, pixB};
  assign pixGrey = CDEPTH'(pixSum / (CDEPTH+2)'(3));

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      pix_q    <= '0;
      blank1_q <= 1'b0;
      videoR_q <= '0;
      videoG_q <= '0;
      videoB_q <= '0;
    end else begin
      pix_q    <= cram[pixIdx];
      blank1_q <= ~HSYN | ~VSYN;
      if (blank1_q) begin
        videoR_q <= '0;
        videoG_q <= '0;
        videoB_q <= '0;
      end else if (cr_q[7]) begin
        videoR_q <= pixGrey;
        videoG_q <= pixGrey;
        videoB_q <= pixGrey;
      end else begin
        videoR_q <= pixR;
        videoG_q <= pixG;
        videoB_q <= pixB;
      end
    end
  end

  vce_dot_clk_gen u_dot_clk_gen (
    .clock     (clock),
    .reset_N   (reset_N),
    .mode_i    (cr_q[1:0]),
    .restart_i (wrFire && (A == VCE_CR)),
    .ck_o      (CK)
  );

  assign D_out   = dOut_q;
  assign D_oe    = rdActive;
  assign VIDEO_R = videoR_q;
  assign VIDEO_G = videoG_q;
  assign VIDEO_B = videoB_q;

endmodule

// File: tb/tb_vce_color_encoder.sv
// Self-checking bench for vce_color_encoder: directed register/pixel cases plus randomized
// CRAM contents and pixel streams checked against a behavioural model of the encoder.
module tb_vce_color_encoder;

  localparam int CDEPTH  = 3;
  localparam int CRAM_AW = 9;

  logic               clock = 1'b0;
  logic               reset_N;
  logic [CRAM_AW-1:0] VD;
  logic               HSYN, VSYN;
  logic [2:0]         A;
  logic [7:0]         D_in;
  logic [7:0]         D_out;
  logic               D_oe;
  logic               RD_n, WR_n, CS_n;
  logic [CDEPTH-1:0]  VIDEO_R, VIDEO_G, VIDEO_B;
  logic               CK;

  vce_color_encoder #(.CDEPTH(CDEPTH), .CRAM_AW(CRAM_AW)) dut (
    .clock   (clock),
    .reset_N (reset_N),
    .VD      (VD),
    .HSYN    (HSYN),
    .VSYN    (VSYN),
    .A       (A),
    .D_in    (D_in),
    .D_out   (D_out),
    .D_oe    (D_oe),
    .RD_n    (RD_n),
    .WR_n    (WR_n),
    .CS_n    (CS_n),
    .VIDEO_R (VIDEO_R),
    .VIDEO_G (VIDEO_G),
    .VIDEO_B (VIDEO_B),
    .CK      (CK)
  );

  always #5 clock = ~clock;

  int compareCount  = 0;
  int mismatchCount = 0;

  // Behavioural model state: colour RAM as integers plus the CPU-visible registers.
  int refCram [512];
  int refAddr, refLatch, refCr;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Expected {R,G,B} for a pixel code; CRAM entries are {G,R,B} with 3 bits each.
  function automatic logic [8:0] expVideo(input int vd, input bit blank);
    int idx, e, g, r, b, y;
    idx = (vd % 16 == 0) ? ((vd >= 256) ? 256 : 0) : vd;
    e = refCram[idx];
    g = e / 64;
    r = (e / 8) % 8;
    b = e % 8;
    if (blank) return 9'd0;
    if ((refCr & 128) != 0) begin
      y = (r + g + b) / 3;
      return 9'(y * 64 + y * 8 + y);
    end
    return 9'(r * 64 + g * 8 + b);
  endfunction

  task automatic busWrite(input int a, input int d);
    @(posedge clock); #1;
    A = 3'(a); D_in = 8'(d); CS_n = 1'b0; WR_n = 1'b0;
    @(posedge clock); #1;
    CS_n = 1'b1; WR_n = 1'b1;
    @(posedge clock); #1;
    case (a)
      0: refCr = d;
      2: refAddr = (refAddr / 256) * 256 + d;
      3: refAddr = (d % 2) * 256 + refAddr % 256;
      4: refLatch = d;
      5: begin
        refCram[refAddr] = (d % 2) * 256 + refLatch;
        refAddr = (refAddr + 1) % 512;
      end
      default: ;
    endcase
  endtask

  task automatic busRead(input int a, input string tag);
    int expv;
    case (a)
      0:       expv = refCr;
      2:       expv = refAddr % 256;
      3:       expv = refAddr / 256;
      4:       expv = refCram[refAddr] % 256;
      5:       expv = refCram[refAddr] / 256;
      default: expv = 0;
    endcase
    @(posedge clock); #1;
    A = 3'(a); CS_n = 1'b0; RD_n = 1'b0;
    @(posedge clock); #1;
    checkOutput(tag, D_out, expv);
    checkOutput($sformatf("%s_oe_on", tag), D_oe, 1);
    CS_n = 1'b1; RD_n = 1'b1;
    #1;
    checkOutput($sformatf("%s_oe_off", tag), D_oe, 0);
    if (a == 5) refAddr = (refAddr + 1) % 512;
  endtask

  task automatic setAddr(input int addr);
    busWrite(2, addr % 256);
    busWrite(3, addr / 256);
  endtask

  task automatic applyPixel(input int vd, input bit hs, input bit vs, input logic [8:0] expected, input string tag);
    @(posedge clock); #1;
    VD = 9'(vd); HSYN = hs; VSYN = vs;
    @(posedge clock);
    @(posedge clock); #1;
    checkOutput(tag, {VIDEO_R, VIDEO_G, VIDEO_B}, expected);
  endtask

  task automatic applyReset();
    @(posedge clock); #1;
    reset_N = 1'b0;
    #2;
    checkOutput("reset_video", {VIDEO_R, VIDEO_G, VIDEO_B}, 0);
    checkOutput("reset_ck", CK, 0);
    checkOutput("reset_dout", D_out, 0);
    checkOutput("reset_doe", D_oe, 0);
    @(negedge clock);
    reset_N = 1'b1;
    refAddr = 0; refLatch = 0; refCr = 0;
  endtask

  task automatic measureDot(input int mode);
    int n, cnt;
    n = (mode == 0) ? 8 : (mode == 1) ? 6 : 4;
    busWrite(0, mode);
    cnt = 0;
    do begin
      @(posedge clock); #1;
      cnt++;
    end while (!CK && cnt < 20);
    checkOutput($sformatf("ck_first_m%0d", mode), cnt, n - 1);
    @(posedge clock); #1;
    checkOutput($sformatf("ck_width_m%0d", mode), CK, 0);
    cnt = 1;
    do begin
      @(posedge clock); #1;
      cnt++;
    end while (!CK && cnt < 20);
    checkOutput($sformatf("ck_period_m%0d", mode), cnt, n);
  endtask

  // Random pixel stream; each expectation is checked two cycles after its inputs.
  task automatic applyStimulus(input int cycles);
    logic [8:0] expQ[$];
    int vd;
    bit hs, vs;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock); #1;
      if (i >= 2) checkOutput($sformatf("stream_%0d", i), {VIDEO_R, VIDEO_G, VIDEO_B}, expQ.pop_front());
      vd = int'($urandom_range(0, 511));
      hs = ($urandom_range(0, 7) != 0);
      vs = ($urandom_range(0, 7) != 0);
      VD = 9'(vd); HSYN = hs; VSYN = vs;
      expQ.push_back(expVideo(vd, !hs || !vs));
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int x, d;
    logic [8:0] oldColour, newColour;
    reset_N = 1'b0;
    VD = '0; HSYN = 1'b1; VSYN = 1'b1;
    A = 3'd0; D_in = 8'h00; RD_n = 1'b1; WR_n = 1'b1; CS_n = 1'b1;
    refAddr = 0; refLatch = 0; refCr = 0;
    for (int i = 0; i < 512; i++) refCram[i] = 0;

    #22;
    checkOutput("reset_video", {VIDEO_R, VIDEO_G, VIDEO_B}, 0);
    checkOutput("reset_ck", CK, 0);
    checkOutput("reset_dout", D_out, 0);
    checkOutput("reset_doe", D_oe, 0);
    @(negedge clock);
    reset_N = 1'b1;
    busRead(2, "rst_addr_lo");
    busRead(0, "rst_cr");

    busWrite(2, 'h10); busWrite(3, 0); busWrite(4, 'hA5); busWrite(5, 'h01);
    busRead(2, "addr_after_commit");
    busRead(3, "addr_hi_after_commit");
    setAddr('h10);
    busRead(4, "data_lo");
    busRead(5, "data_hi");
    busRead(2, "addr_after_read_hi");

    setAddr('h1FF);
    busWrite(4, 'h3F); busWrite(5, 'h00);
    busRead(2, "wrap_lo");
    busRead(3, "wrap_hi");
    setAddr('h1FF);
    busRead(4, "wrap_data_lo");
    busRead(5, "wrap_data_hi");
    busRead(2, "wrap_read_lo");

    setAddr(0);
    busWrite(4, 'hC0); busWrite(5, 'h01);
    applyPixel('h020, 1, 1, 9'h038, "bg_pixel");
    applyPixel('h020, 0, 1, 9'h000, "hsync_blank");
    applyPixel('h020, 1, 0, 9'h000, "vsync_blank");

    setAddr(5);
    busWrite(4, 'h98); busWrite(5, 'h01);
    busWrite(0, 'h80);
    busRead(0, "cr_grey");
    applyPixel(5, 1, 1, 9'h0DB, "grey");
    busWrite(0, 'h00);
    applyPixel(5, 1, 1, 9'h0F0, "colour");

    measureDot(1);
    measureDot(2);
    measureDot(0);
    measureDot(3);

    setAddr('h40);
    busWrite(4, 'hA5);
    applyReset();
    busWrite(5, 'h01);
    setAddr(0);
    busRead(4, "rst_latch_lo");
    busRead(5, "rst_latch_hi");

    setAddr(0);
    for (int i = 0; i < 512; i++) begin
      d = int'($urandom_range(0, 511));
      busWrite(4, d % 256);
      busWrite(5, d / 256);
    end
    busRead(2, "fill_wrap_lo");
    busRead(3, "fill_wrap_hi");
    for (int i = 0; i < 16; i++) begin
      setAddr(int'($urandom_range(0, 511)));
      busRead(4, $sformatf("rand_lo_%0d", i));
      busRead(5, $sformatf("rand_hi_%0d", i));
    end

    busWrite(0, 'h00);
    x = 'h0A5;
    @(posedge clock); #1;
    VD = 9'(x); HSYN = 1'b1; VSYN = 1'b1;
    setAddr(x);
    d = refCram[x] ^ 'h1FF;
    busWrite(4, d % 256);
    oldColour = expVideo(x, 0);
    busWrite(5, d / 256);
    newColour = expVideo(x, 0);
    checkOutput("collision_pre", {VIDEO_R, VIDEO_G, VIDEO_B}, oldColour);
    @(posedge clock); #1;
    checkOutput("collision_old", {VIDEO_R, VIDEO_G, VIDEO_B}, oldColour);
    @(posedge clock); #1;
    checkOutput("collision_new", {VIDEO_R, VIDEO_G, VIDEO_B}, newColour);

    busWrite(0, 'h00);
    applyStimulus(150);
    busWrite(0, 'h80 | int'($urandom_range(0, 3)));
    applyStimulus(150);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
